// File: rtl/mux_rr_nch.sv
// mux_rr_nch
// ----------
// Registered NCH-channel, WIDTH-bit multiplexer between several producers
// and one shared consumer. Each input channel and the output carry a
// valid/ready handshake. The channel to forward is chosen either by the
// select input S (MODE=0) or by a round-robin scan over the requesting
// channels (MODE=1). The output register holds one word.
//
// Ports
//   CLK       : clock, rising edge
//   RST_N     : asynchronous active-low reset
//   A         : flattened channel data, channel k = A[k*WIDTH +: WIDTH]
//   VALID_IN  : per-channel request
//   READY_IN  : per-channel accept (combinational, at most one bit high)
//   MODE      : 0 = fixed select by S, 1 = round-robin
//   S         : channel index used when MODE=0
//   Y         : registered output data
//   Y_VALID   : Y holds a valid word
//   Y_READY   : consumer accepts Y this cycle
//   Y_CH      : index of the channel that produced Y
//
// Handshake: a word moves across an interface on a rising edge where both
// its valid and its ready are high. Producers hold data steady while valid
// is high and ready is low. READY_IN depends combinationally on VALID_IN,
// MODE, S, Y_VALID and Y_READY; Y_VALID depends only on registered state,
// so there is no combinational path from VALID_IN to Y_VALID.

module mux_rr_nch #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NCH*WIDTH-1:0] A,
    input  logic [NCH-1:0]       VALID_IN,
    output logic [NCH-1:0]       READY_IN,
    input  logic                 MODE,
    input  logic [SELW-1:0]      S,
    output logic [WIDTH-1:0]     Y,
    output logic                 Y_VALID,
    input  logic                 Y_READY,
    output logic [SELW-1:0]      Y_CH
);

    // Round-robin pointer: the channel granted by the most recent MODE=1
    // load. The scan starts one past it, so resetting it to NCH-1 gives
    // channel 0 first priority.
    logic [SELW-1:0]  last;

    logic             grant_valid;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             load;

    // Grant decision. In MODE=0 an out-of-range S simply matches no channel.
    // In MODE=1 the outer loop walks the scan order last+1 .. last+NCH and
    // the first requesting channel wins; grant_valid blocks later matches.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!MODE) begin
            for (int k = 0; k < NCH; k++) begin
                if (S == SELW'(k) && VALID_IN[k]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(k);
                end
            end
        end else begin
            for (int i = 1; i <= NCH; i++) begin
                for (int k = 0; k < NCH; k++) begin
                    if (!grant_valid && VALID_IN[k] &&
                        k == ((int'(last) + i) % NCH)) begin
                        grant_valid = 1'b1;
                        grant_idx   = SELW'(k);
                    end
                end
            end
        end
    end

    // Data of the granted channel.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant_idx == SELW'(k)) begin
                grant_data = A[k*WIDTH +: WIDTH];
            end
        end
    end

    // Load when the register is empty or being drained this cycle. RST_N
    // gates it so no producer sees an accept while the block is in reset.
    assign load = RST_N && grant_valid && (!Y_VALID || Y_READY);

    always_comb begin
        READY_IN = '0;
        for (int k = 0; k < NCH; k++) begin
            READY_IN[k] = load && (grant_idx == SELW'(k));
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Y       <= '0;
            Y_VALID <= 1'b0;
            Y_CH    <= '0;
            last    <= SELW'(NCH - 1);
        end else begin
            if (load) begin
                Y       <= grant_data;
                Y_CH    <= grant_idx;
                Y_VALID <= 1'b1;
                if (MODE) begin
                    last <= grant_idx;
                end
            end else if (Y_VALID && Y_READY) begin
                // Drain: Y and Y_CH keep their last values.
                Y_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_nch.sv
// Directed bench for mux_rr_nch with WIDTH=8, NCH=4.
module tb_mux_rr_nch;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NCH*WIDTH-1:0] a;
    logic [NCH-1:0]       valid_in;
    logic [NCH-1:0]       ready_in;
    logic                 mode;
    logic [SELW-1:0]      s;
    logic [WIDTH-1:0]     y;
    logic                 y_valid;
    logic                 y_ready;
    logic [SELW-1:0]      y_ch;

    int total = 0;
    int bad   = 0;

    mux_rr_nch #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .A        (a),
        .VALID_IN (valid_in),
        .READY_IN (ready_in),
        .MODE     (mode),
        .S        (s),
        .Y        (y),
        .Y_VALID  (y_valid),
        .Y_READY  (y_ready),
        .Y_CH     (y_ch)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full output check: data, valid and channel.
    task automatic chk_out(input string tag, input logic [7:0] ey, input logic ev, input logic [1:0] ech);
        chk({tag, ".y"},       32'(y),       32'(ey));
        chk({tag, ".y_valid"}, 32'(y_valid), 32'(ev));
        chk({tag, ".y_ch"},    32'(y_ch),    32'(ech));
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [7:0] d);
        a[k*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        rst_n    = 1'b0;
        a        = '0;
        set_ch(0, 8'h10);
        set_ch(1, 8'h21);
        set_ch(2, 8'hA5);
        set_ch(3, 8'h3C);
        valid_in = 4'b1111;
        mode     = 1'b0;
        s        = 2'd0;
        y_ready  = 1'b1;

        // Reset with every channel requesting, before any clock edge.
        #3;
        chk_out("rst_noclk", 8'h00, 1'b0, 2'd0);
        chk("rst_noclk.ready_in", 32'(ready_in), 32'h0);
        // Still cleared across a rising edge while held in reset.
        tick();
        chk_out("rst_edge", 8'h00, 1'b0, 2'd0);
        chk("rst_edge.ready_in", 32'(ready_in), 32'h0);

        // Fixed select S=2.
        @(negedge clk);
        rst_n = 1'b1;
        s     = 2'd2;
        #1;
        chk("fix2.ready_in", 32'(ready_in), 32'b0100);
        tick();
        chk_out("fix2", 8'hA5, 1'b1, 2'd2);

        // Fixed select S=3; register full but draining, so it reloads.
        s = 2'd3;
        #1;
        chk("fix3.ready_in", 32'(ready_in), 32'b1000);
        tick();
        chk_out("fix3", 8'h3C, 1'b1, 2'd3);

        // Round-robin, all requesting. The MODE=0 loads left the pointer at
        // its reset value, so the sequence starts at channel 0.
        mode = 1'b1;
        #1;
        chk("rr.ready_in", 32'(ready_in), 32'b0001);
        tick(); chk_out("rr0", 8'h10, 1'b1, 2'd0);
        tick(); chk_out("rr1", 8'h21, 1'b1, 2'd1);
        tick(); chk_out("rr2", 8'hA5, 1'b1, 2'd2);
        tick(); chk_out("rr3", 8'h3C, 1'b1, 2'd3);
        tick(); chk_out("rr4", 8'h10, 1'b1, 2'd0);
        tick(); chk_out("rr5", 8'h21, 1'b1, 2'd1);

        // Channels 1 and 3 only; last=1, so 3 comes first.
        valid_in = 4'b1010;
        tick(); chk("alt0.y_ch", 32'(y_ch), 32'd3);
        tick(); chk("alt1.y_ch", 32'(y_ch), 32'd1);
        tick(); chk("alt2.y_ch", 32'(y_ch), 32'd3);
        tick(); chk("alt3.y_ch", 32'(y_ch), 32'd1);

        // Single requester: channel 1 with 8'h11, granted again.
        valid_in = 4'b0010;
        set_ch(1, 8'h11);
        tick(); chk_out("single", 8'h11, 1'b1, 2'd1);

        // Backpressure for 5 cycles with every channel requesting.
        y_ready  = 1'b0;
        valid_in = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold.ready_in", 32'(ready_in), 32'h0);
            tick();
            chk_out("hold", 8'h11, 1'b1, 2'd1);
        end

        // Release: last=1, so channel 2 loads on the same edge as the drain.
        y_ready = 1'b1;
        #1;
        chk("release.ready_in", 32'(ready_in), 32'b0100);
        tick();
        chk_out("release", 8'hA5, 1'b1, 2'd2);

        // Drain to idle; Y and Y_CH keep their values.
        valid_in = 4'b0000;
        #1;
        chk("drain.ready_in", 32'(ready_in), 32'h0);
        tick();
        chk_out("drain", 8'hA5, 1'b0, 2'd2);

        // Fixed select on a non-requesting channel: no grant.
        mode     = 1'b0;
        s        = 2'd1;
        valid_in = 4'b1101;
        #1;
        chk("nogrant.ready_in", 32'(ready_in), 32'h0);
        tick();
        chk_out("nogrant", 8'hA5, 1'b0, 2'd2);

        // Round-robin streaming, then a reset pulse between clock edges.
        mode     = 1'b1;
        valid_in = 4'b1111;
        tick(); chk_out("pre_rst0", 8'h3C, 1'b1, 2'd3);
        tick(); chk_out("pre_rst1", 8'h10, 1'b1, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 8'h00, 1'b0, 2'd0);
        chk("mid_rst.ready_in", 32'(ready_in), 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst.ready_in", 32'(ready_in), 32'b0001);
        tick();
        chk_out("post_rst", 8'h10, 1'b1, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
